// File: rtl/lcd_controller_if.sv
// Byte/command handshake between the LCD bus interface (master) and lcd_controller (slave).
interface lcd_controller_if;
    logic [7:0] data;
    logic       data_is_cmd;
    logic       data_req;
    logic       data_ack;
    logic       busy;

    modport master (output data, data_is_cmd, data_req, input data_ack, busy);
    modport slave  (input data, data_is_cmd, data_req, output data_ack, busy);
endinterface

// File: rtl/lcd_controller.sv
// HD44780 8-bit write-only sequencer: power-on wait, setup / E pulse / exec wait, four-phase ack.
// Define LCD_CTRL_INIT_EN to compile in the built-in 6-byte init sequence after power-on.
module lcd_controller #(
    parameter int SETUP_CYCLES      = 2,
    parameter int E_PULSE_CYCLES    = 25,
    parameter int CMD_WAIT_CYCLES   = 2500,
    parameter int CLEAR_WAIT_CYCLES = 100000,
    parameter int POWER_ON_CYCLES   = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    lcd_controller_if.slave  bus,
    output logic             lcd_e,
    output logic             lcd_rs,
    output logic             lcd_rw,
    output logic [7:0]       lcd_data
);

    typedef enum logic [2:0] {
        S_POWER_WAIT,
`ifdef LCD_CTRL_INIT_EN
        S_INIT_LOAD,
`endif
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_ACK,
        S_IDLE
    } state_t;

    localparam logic [23:0] LD_POWER = 24'(POWER_ON_CYCLES - 1);
    localparam logic [23:0] LD_SETUP = 24'(SETUP_CYCLES - 1);
    localparam logic [23:0] LD_PULSE = 24'(E_PULSE_CYCLES - 1);
    localparam logic [23:0] LD_CMD   = 24'(CMD_WAIT_CYCLES - 1);
    localparam logic [23:0] LD_CLEAR = 24'(CLEAR_WAIT_CYCLES - 1);

    state_t      state_q;
    logic [23:0] cnt_q;
    logic        e_q, rs_q, ack_q, busy_q;
    logic [7:0]  data_q;
    logic        is_clear;

`ifdef LCD_CTRL_INIT_EN
    logic       init_q;
    logic [2:0] idx_q;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction
`endif

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign is_clear = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_POWER_WAIT;
            cnt_q   <= LD_POWER;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef LCD_CTRL_INIT_EN
            init_q  <= 1'b1;
            idx_q   <= 3'd0;
`endif
        end else begin
            case (state_q)
                S_POWER_WAIT: begin
                    if (cnt_q == 24'd0) begin
`ifdef LCD_CTRL_INIT_EN
                        state_q <= S_INIT_LOAD;
`else
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        cnt_q <= cnt_q - 24'd1;
                    end
                end
`ifdef LCD_CTRL_INIT_EN
                S_INIT_LOAD: begin
                    data_q  <= init_byte(idx_q);
                    rs_q    <= 1'b0;
                    cnt_q   <= LD_SETUP;
                    state_q <= S_SETUP;
                end
`endif
                S_IDLE: begin
                    if (bus.data_req) begin
                        data_q  <= bus.data;
                        rs_q    <= !bus.data_is_cmd;
                        cnt_q   <= LD_SETUP;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == 24'd0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= LD_PULSE;
                        state_q <= S_PULSE;
                    end else begin
                        cnt_q <= cnt_q - 24'd1;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == 24'd0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= is_clear ? LD_CLEAR : LD_CMD;
                        state_q <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q - 24'd1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 24'd0) begin
`ifdef LCD_CTRL_INIT_EN
                        if (init_q) begin
                            if (idx_q == 3'd5) begin
                                init_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end else begin
                                idx_q   <= idx_q + 3'd1;
                                state_q <= S_INIT_LOAD;
                            end
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= S_ACK;
                        end
`else
                        ack_q   <= 1'b1;
                        state_q <= S_ACK;
`endif
                    end else begin
                        cnt_q <= cnt_q - 24'd1;
                    end
                end
                S_ACK: begin
                    if (!bus.data_req) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_POWER_WAIT;
                    cnt_q   <= LD_POWER;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign lcd_e        = e_q;
    assign lcd_rs       = rs_q;
    assign lcd_rw       = 1'b0;
    assign lcd_data     = data_q;
    assign bus.data_ack = ack_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller with short timing parameters; handles both init builds.
module tb_lcd_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    int         n_chk = 0;
    int         n_bad = 0;

    lcd_controller_if bus();

    lcd_controller #(
        .SETUP_CYCLES(2), .E_PULSE_CYCLES(3), .CMD_WAIT_CYCLES(5),
        .CLEAR_WAIT_CYCLES(20), .POWER_ON_CYCLES(10)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

`ifdef LCD_CTRL_INIT_EN
    localparam int N_RISE  = 7;
    localparam int T_BUSY0 = 90;
    localparam int T_ACC   = 91;
    localparam logic [7:0] RISE_D [0:6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06, 8'h41};
    localparam int         RISE_T [0:6] = '{12, 23, 34, 45, 56, 82, 93};
`else
    localparam int N_RISE  = 1;
    localparam int T_BUSY0 = 9;
    localparam int T_ACC   = 10;
    localparam logic [7:0] RISE_D [0:0] = '{8'h41};
    localparam int         RISE_T [0:0] = '{12};
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One user transfer starting at a negedge with the DUT in IDLE; w is the expected exec wait.
    task automatic xfer(input logic [7:0] b, input logic cmd, input int w, input int hold);
        int   t_rise, t_fall, t_ack, rises;
        logic prev_e, bad;
        bus.data = b; bus.data_is_cmd = cmd; bus.data_req = 1'b1;
        t_rise = -1; t_fall = -1; t_ack = -1; rises = 0; prev_e = 1'b0; bad = 1'b0;
        for (int t = 0; t < 200 && t_ack < 0; t++) begin
            @(posedge clk); @(negedge clk);
            if (t == 0) begin
                chk("acc_rs", lcd_rs, !cmd);
                chk("acc_data", lcd_data, b);
            end
            if (lcd_data !== b || lcd_rs !== !cmd || lcd_rw !== 1'b0) bad = 1'b1;
            if (lcd_e && !prev_e) begin
                rises++;
                if (t_rise < 0) t_rise = t;
                bus.data = ~b; bus.data_is_cmd = !cmd;
            end
            if (!lcd_e && prev_e && t_fall < 0) t_fall = t;
            if (bus.data_ack) t_ack = t;
            prev_e = lcd_e;
        end
        chk("e_rise", t_rise, 2);
        chk("e_fall", t_fall, 5);
        chk("ack_lat", t_ack, 5 + w);
        chk("n_pulse", rises, 1);
        chk("bus_hold", bad, 0);
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (!bus.data_ack || lcd_e || lcd_data !== b) bad = 1'b1;
        end
        chk("ack_hold", bad, 0);
        bus.data_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("ack_drop", bus.data_ack, 0);
        chk("busy_idle", bus.busy, 0);
    endtask

    task automatic wait_idle(input string tag);
        int ok = 0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) ok = 1;
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        int         rises, t_busy0, t_acc, t_ack;
        int         rise_t [0:7];
        logic [7:0] rise_d [0:7];
        logic       rise_rs [0:7];
        logic       prev_e, bad;

        bus.data = 8'h00; bus.data_is_cmd = 1'b0; bus.data_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_e", lcd_e, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_ack", bus.data_ack, 0);
        chk("rst_busy", bus.busy, 1);

        // Boot with a request raised one cycle after reset release.
        rst = 1'b0;
        rises = 0; t_busy0 = -1; t_acc = -1; t_ack = -1; prev_e = 1'b0; bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rise_t[i] = -1; rise_d[i] = 8'h00; rise_rs[i] = 1'b0;
        end
        for (int t = 0; t < 400 && t_ack < 0; t++) begin
            @(posedge clk); @(negedge clk);
            if (t == 0) begin
                bus.data = 8'h41; bus.data_is_cmd = 1'b0; bus.data_req = 1'b1;
            end
            if (lcd_rw !== 1'b0) bad = 1'b1;
            if (lcd_e && !prev_e) begin
                if (rises < 8) begin
                    rise_t[rises] = t; rise_d[rises] = lcd_data; rise_rs[rises] = lcd_rs;
                end
                rises++;
            end
            if (bus.busy === 1'b0 && t_busy0 < 0) t_busy0 = t;
            if (lcd_rs === 1'b1 && t_acc < 0) t_acc = t;
            if (bus.data_ack) t_ack = t;
            prev_e = lcd_e;
        end
        chk("boot_pulses", rises, N_RISE);
        chk("boot_busy0", t_busy0, T_BUSY0);
        chk("boot_accept", t_acc, T_ACC);
        chk("boot_ack", t_ack, T_ACC + 10);
        chk("boot_rw", bad, 0);
        for (int i = 0; i < N_RISE; i++) begin
            chk("boot_rise_t", rise_t[i], RISE_T[i]);
            chk("boot_rise_d", rise_d[i], RISE_D[i]);
            chk("boot_rise_rs", rise_rs[i], (i == N_RISE - 1) ? 1 : 0);
        end
        bus.data_req = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("boot_ack_drop", bus.data_ack, 0);
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (lcd_e || bus.data_ack || bus.busy) bad = 1'b1;
        end
        chk("boot_single", bad, 0);

        xfer(8'h42, 1'b0, 5, 0);
        xfer(8'h01, 1'b1, 20, 0);
        xfer(8'h04, 1'b1, 5, 0);
        xfer(8'h02, 1'b1, 20, 0);
        xfer(8'h03, 1'b1, 20, 0);
        xfer(8'h01, 1'b0, 5, 0);
        xfer(8'h00, 1'b1, 5, 7);

        // Reset while E is high.
        bus.data = 8'h77; bus.data_is_cmd = 1'b0; bus.data_req = 1'b1;
        bad = 1'b1;
        for (int i = 0; i < 20 && bad; i++) begin
            @(negedge clk);
            if (lcd_e) bad = 1'b0;
        end
        chk("mid_e_seen", bad, 0);
        #2 rst = 1'b1;
        bus.data_req = 1'b0;
        #1;
        chk("mid_e_async", lcd_e, 0);
        chk("mid_ack", bus.data_ack, 0);
        chk("mid_busy", bus.busy, 1);
        chk("mid_data", lcd_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int t = 0; t < 9; t++) begin
            @(posedge clk); @(negedge clk);
            if (lcd_e || !bus.busy || bus.data_ack) bad = 1'b1;
        end
        chk("restart_pw", bad, 0);
        wait_idle("restart_idle");
        chk("restart_noack", bus.data_ack, 0);
        xfer(8'h33, 1'b0, 5, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
